// File: rtl/mdu_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mdu_issue_scheduler_pkg
// Shared types and constants for the multiply/divide issue scheduler.
//   mdu_operation_t   : decoded MDU opcode, shared with the MDU datapath.
//   mdu_sched_state_t : scheduler FSM state encoding.
//   DEF_*             : default latencies and countdown width.
//   is_mul_op/is_div_op : classify the ops that start a multi-cycle window.
// ---------------------------------------------------------------------------
package mdu_issue_scheduler_pkg;

  typedef enum logic [2:0] {
    MDU_START_SIGNED_MUL   = 3'd0,
    MDU_START_UNSIGNED_MUL = 3'd1,
    MDU_START_SIGNED_DIV   = 3'd2,
    MDU_START_UNSIGNED_DIV = 3'd3,
    MDU_READ_HI            = 3'd4,
    MDU_READ_LO            = 3'd5,
    MDU_WRITE_HI           = 3'd6,
    MDU_WRITE_LO           = 3'd7
  } mdu_operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_MUL = 2'd1,
    BUSY_DIV = 2'd2
  } mdu_sched_state_t;

  localparam int DEF_MUL_LATENCY = 5;
  localparam int DEF_DIV_LATENCY = 10;
  localparam int DEF_CNT_W       = 4;

  function automatic logic is_mul_op(input mdu_operation_t op);
    return (op == MDU_START_SIGNED_MUL) || (op == MDU_START_UNSIGNED_MUL);
  endfunction

  function automatic logic is_div_op(input mdu_operation_t op);
    return (op == MDU_START_SIGNED_DIV) || (op == MDU_START_UNSIGNED_DIV);
  endfunction

endpackage

// File: rtl/mdu_issue_scheduler_busy_counter.sv
// ---------------------------------------------------------------------------
// mdu_busy_counter
// Loadable down-counter tracking the remaining busy cycles of the MDU.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   load       in   load load_value this cycle (takes priority over decrement)
//   load_value in   value to load
//   clear      in   force count to zero (illegal-state recovery)
//   count      out  remaining busy cycles
//   nonzero    out  count != 0
// The count decrements every cycle while nonzero; it never waits on stalls.
// ---------------------------------------------------------------------------
module mdu_busy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/mdu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// mdu_issue_scheduler
// Sequences access to the shared multiply/divide unit from the ID stage.
// Issues at most one MDU op per cycle into EX, tracks the busy window of
// mult/div, and stalls ID while an MDU instruction would collide with it.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   id_valid      in   ID holds a real instruction
//   id_mdu_use    in   ID instruction uses the MDU
//   id_mdu_op     in   decoded MDU opcode
//   id_flush      in   squash the ID instruction this cycle
//   ex_stall      in   downstream freeze, EX cannot accept an op
//   stall_id      out  hold PC/IF/ID, inject bubble into EX
//   mdu_issue     out  one-cycle pulse: op accepted into EX
//   mdu_issue_op  out  opcode qualified by mdu_issue
//   mdu_busy      out  mult/div in flight
//   busy_count    out  remaining busy cycles
//   stall_cycles  out  saturating count of stall_id cycles (MDU_STALL_CNT_EN)
//
// Optional feature macro: MDU_STALL_CNT_EN adds the stall_cycles counter.
//
// FSM states:
//   state    | meaning
//   IDLE     | no mult/div in flight, any MDU op may issue
//   BUSY_MUL | mult in flight, MDU ops in ID stall
//   BUSY_DIV | div in flight, MDU ops in ID stall
// ---------------------------------------------------------------------------
module mdu_issue_scheduler
  import mdu_issue_scheduler_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_mdu_use,
  input  mdu_operation_t   id_mdu_op,
  input  logic             id_flush,
  input  logic             ex_stall,
  output logic             stall_id,
  output logic             mdu_issue,
  output mdu_operation_t   mdu_issue_op,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] busy_count
`ifdef MDU_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_BUSY_MUL = BUSY_MUL;
  localparam logic [1:0] ST_BUSY_DIV = BUSY_DIV;

  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_LATENCY);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] count;
  logic             count_nonzero;
  logic             mdu_req;
  logic             start_mul;
  logic             start_div;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             state_illegal;

  // Flush dominates both stall and issue; a busy window keeps counting.
  assign mdu_req      = id_valid & id_mdu_use & ~id_flush;
  assign mdu_busy     = count_nonzero;
  assign busy_count   = count;
  assign stall_id     = mdu_req & count_nonzero;
  assign mdu_issue    = mdu_req & ~count_nonzero & ~ex_stall;
  assign mdu_issue_op = mdu_issue ? id_mdu_op : MDU_START_SIGNED_MUL;

  // HI/LO moves issue with zero busy time, so only mult/div load the counter.
  assign start_mul      = mdu_issue & is_mul_op(id_mdu_op);
  assign start_div      = mdu_issue & is_div_op(id_mdu_op);
  assign cnt_load       = start_mul | start_div;
  assign cnt_load_value = start_div ? DIV_LAT : MUL_LAT;
  assign state_illegal  = (state != ST_IDLE) && (state != ST_BUSY_MUL) &&
                          (state != ST_BUSY_DIV);

  mdu_busy_counter #(
    .CNT_W (CNT_W)
  ) u_busy_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .clear      (state_illegal),
    .count      (count),
    .nonzero    (count_nonzero)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_mul) begin
          state_next = ST_BUSY_MUL;
        end else if (start_div) begin
          state_next = ST_BUSY_DIV;
        end
      end
      ST_BUSY_MUL, ST_BUSY_DIV: begin
        // Leaves on the 1->0 count transition.
        if (count <= CNT_W'(1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef MDU_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (stall_id && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue_scheduler
// Directed scenarios plus a randomized run against a cycle-level model that
// tracks the remaining busy cycles as a plain integer.
// ---------------------------------------------------------------------------
module tb_mdu_issue_scheduler;
  import mdu_issue_scheduler_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           id_valid;
  logic           id_mdu_use;
  mdu_operation_t id_mdu_op;
  logic           id_flush;
  logic           ex_stall;
  logic           stall_id;
  logic           mdu_issue;
  mdu_operation_t mdu_issue_op;
  logic           mdu_busy;
  logic [3:0]     busy_count;
`ifdef MDU_STALL_CNT_EN
  logic [31:0]    stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;
  int m_count = 0;

  mdu_issue_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_mdu_use   (id_mdu_use),
    .id_mdu_op    (id_mdu_op),
    .id_flush     (id_flush),
    .ex_stall     (ex_stall),
    .stall_id     (stall_id),
    .mdu_issue    (mdu_issue),
    .mdu_issue_op (mdu_issue_op),
    .mdu_busy     (mdu_busy),
    .busy_count   (busy_count)
`ifdef MDU_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Reference: remaining busy cycles, loaded with the op latency on a
  // mult/div acceptance, otherwise counting down to zero.
  always @(posedge clock) begin
    if (!reset) begin
      m_count <= 0;
    end else if (id_valid && id_mdu_use && m_count == 0 && !ex_stall && !id_flush &&
                 id_mdu_op inside {MDU_START_SIGNED_MUL, MDU_START_UNSIGNED_MUL}) begin
      m_count <= 5;
    end else if (id_valid && id_mdu_use && m_count == 0 && !ex_stall && !id_flush &&
                 id_mdu_op inside {MDU_START_SIGNED_DIV, MDU_START_UNSIGNED_DIV}) begin
      m_count <= 10;
    end else if (m_count > 0) begin
      m_count <= m_count - 1;
    end
  end

  task automatic drive(input logic v, input logic u, input mdu_operation_t op,
                       input logic fl, input logic es);
    id_valid   = v;
    id_mdu_use = u;
    id_mdu_op  = op;
    id_flush   = fl;
    ex_stall   = es;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 1'b0, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clock);
    n_vec++;
    if (stall_id !== 1'b0 || mdu_issue !== 1'b0 || mdu_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: stall=%b issue=%b busy=%b want 0 0 0", stall_id, mdu_issue, mdu_busy);
    end
    n_vec++;
    if (busy_count !== 4'd0 || mdu_issue_op !== MDU_START_SIGNED_MUL) begin
      n_err++;
      $display("FAIL reset_val: count=%0d op=%0d want 0 0", busy_count, mdu_issue_op);
    end
`ifdef MDU_STALL_CNT_EN
    n_vec++;
    if (stall_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
    end
`endif
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_mult_busy();
    drive(1'b1, 1'b1, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++;
    if (mdu_issue !== 1'b1 || mdu_issue_op !== MDU_START_SIGNED_MUL) begin
      n_err++;
      $display("FAIL mult_issue: issue=%b op=%0d want 1 0", mdu_issue, mdu_issue_op);
    end
    next_cycle();
    drive(1'b0, 1'b0, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      n_vec++;
      if (busy_count !== 4'((i <= 5) ? 6 - i : 0) || mdu_busy !== (i <= 5)) begin
        n_err++;
        $display("FAIL mult_window T+%0d: count=%0d busy=%b want %0d %b",
                 i, busy_count, mdu_busy, (i <= 5) ? 6 - i : 0, i <= 5);
      end
      next_cycle();
    end
  endtask

  task automatic test_mflo_stall();
`ifdef MDU_STALL_CNT_EN
    logic [31:0] sc_before;
    sc_before = stall_cycles;
`endif
    drive(1'b1, 1'b1, MDU_START_UNSIGNED_MUL, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, MDU_READ_LO, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      n_vec++;
      if (stall_id !== 1'b1 || mdu_issue !== 1'b0) begin
        n_err++;
        $display("FAIL mflo_stall T+%0d: stall=%b issue=%b want 1 0", i, stall_id, mdu_issue);
      end
      next_cycle();
    end
    @(negedge clock);
    n_vec++;
    if (stall_id !== 1'b0 || mdu_issue !== 1'b1 || mdu_issue_op !== MDU_READ_LO) begin
      n_err++;
      $display("FAIL mflo_issue: stall=%b issue=%b op=%0d want 0 1 5", stall_id, mdu_issue, mdu_issue_op);
    end
    next_cycle();
    drive(1'b0, 1'b0, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
`ifdef MDU_STALL_CNT_EN
    @(negedge clock);
    n_vec++;
    if (stall_cycles - sc_before !== 32'd5) begin
      n_err++;
      $display("FAIL stall_cycles: got delta %0d want 5", stall_cycles - sc_before);
    end
`endif
    idle_cycles(2);
  endtask

  task automatic test_divu_addu();
    drive(1'b1, 1'b1, MDU_START_UNSIGNED_DIV, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++;
    if (stall_id !== 1'b0 || busy_count !== 4'd10 || mdu_issue !== 1'b0) begin
      n_err++;
      $display("FAIL divu_addu: stall=%b count=%0d issue=%b want 0 10 0", stall_id, busy_count, mdu_issue);
    end
    next_cycle();
    drive(1'b1, 1'b1, MDU_READ_HI, 1'b0, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      @(negedge clock);
      n_vec++;
      if (stall_id !== 1'b1 || mdu_issue !== 1'b0) begin
        n_err++;
        $display("FAIL mfhi_stall T+%0d: stall=%b issue=%b want 1 0", i, stall_id, mdu_issue);
      end
      next_cycle();
    end
    @(negedge clock);
    n_vec++;
    if (stall_id !== 1'b0 || mdu_issue !== 1'b1 || mdu_issue_op !== MDU_READ_HI) begin
      n_err++;
      $display("FAIL mfhi_issue T+11: stall=%b issue=%b op=%0d want 0 1 4", stall_id, mdu_issue, mdu_issue_op);
    end
    next_cycle();
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, MDU_WRITE_HI, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++;
    if (mdu_issue !== 1'b1 || stall_id !== 1'b0 || mdu_issue_op !== MDU_WRITE_HI) begin
      n_err++;
      $display("FAIL mthi: issue=%b stall=%b op=%0d want 1 0 6", mdu_issue, stall_id, mdu_issue_op);
    end
    next_cycle();
    drive(1'b1, 1'b1, MDU_WRITE_LO, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++;
    if (mdu_issue !== 1'b1 || stall_id !== 1'b0 || busy_count !== 4'd0) begin
      n_err++;
      $display("FAIL mtlo: issue=%b stall=%b count=%0d want 1 0 0", mdu_issue, stall_id, busy_count);
    end
    next_cycle();
    drive(1'b0, 1'b0, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++;
    if (busy_count !== 4'd0 || mdu_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mt_after: count=%0d busy=%b want 0 0", busy_count, mdu_busy);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, MDU_START_SIGNED_DIV, 1'b0, 1'b0);
    next_cycle();
    idle_cycles(2);
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (busy_count !== 4'd8) begin
      n_err++;
      $display("FAIL div_count T+3: got %0d want 8", busy_count);
    end
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 1'b1, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++;
    if (busy_count !== 4'd0 || mdu_busy !== 1'b0 || mdu_issue !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid T+4: count=%0d busy=%b issue=%b want 0 0 1", busy_count, mdu_busy, mdu_issue);
    end
    next_cycle();
    idle_cycles(6);
  endtask

  task automatic test_ex_stall_flush();
    drive(1'b1, 1'b1, MDU_START_SIGNED_MUL, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_vec++;
      if (mdu_issue !== 1'b0 || stall_id !== 1'b0) begin
        n_err++;
        $display("FAIL ex_stall %0d: issue=%b stall=%b want 0 0", i, mdu_issue, stall_id);
      end
      next_cycle();
    end
    ex_stall = 1'b0;
    @(negedge clock);
    n_vec++;
    if (mdu_issue !== 1'b1) begin
      n_err++;
      $display("FAIL ex_release: issue=%b want 1", mdu_issue);
    end
    next_cycle();
    // Flushed MDU op while busy: no stall, countdown keeps running.
    drive(1'b1, 1'b1, MDU_READ_HI, 1'b1, 1'b0);
    @(negedge clock);
    n_vec++;
    if (stall_id !== 1'b0 || mdu_issue !== 1'b0 || busy_count !== 4'd5) begin
      n_err++;
      $display("FAIL flush_busy: stall=%b issue=%b count=%0d want 0 0 5", stall_id, mdu_issue, busy_count);
    end
    next_cycle();
    drive(1'b1, 1'b1, MDU_READ_HI, 1'b0, 1'b1);
    @(negedge clock);
    n_vec++;
    if (stall_id !== 1'b1 || busy_count !== 4'd4) begin
      n_err++;
      $display("FAIL stall_with_ex: stall=%b count=%0d want 1 4", stall_id, busy_count);
    end
    next_cycle();
    idle_cycles(5);
    drive(1'b1, 1'b1, MDU_START_SIGNED_MUL, 1'b1, 1'b0);
    @(negedge clock);
    n_vec++;
    if (mdu_issue !== 1'b0 || stall_id !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: issue=%b stall=%b want 0 0", mdu_issue, stall_id);
    end
    next_cycle();
    drive(1'b0, 1'b0, MDU_START_SIGNED_MUL, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++;
    if (mdu_busy !== 1'b0 || busy_count !== 4'd0) begin
      n_err++;
      $display("FAIL flush_no_load: busy=%b count=%0d want 0 0", mdu_busy, busy_count);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic           e_issue;
    logic           e_stall;
    mdu_operation_t e_op;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            mdu_operation_t'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      @(negedge clock);
      e_stall = id_valid && id_mdu_use && !id_flush && (m_count > 0);
      e_issue = id_valid && id_mdu_use && !id_flush && (m_count == 0) && !ex_stall;
      e_op    = e_issue ? id_mdu_op : MDU_START_SIGNED_MUL;
      n_vec++;
      if (stall_id !== e_stall || mdu_issue !== e_issue || mdu_issue_op !== e_op) begin
        n_err++;
        $display("FAIL rand_ctl %0d: stall=%b issue=%b op=%0d want %b %b %0d",
                 i, stall_id, mdu_issue, mdu_issue_op, e_stall, e_issue, e_op);
      end
      n_vec++;
      if (busy_count !== 4'(m_count) || mdu_busy !== (m_count > 0)) begin
        n_err++;
        $display("FAIL rand_count %0d: count=%0d busy=%b want %0d %b",
                 i, busy_count, mdu_busy, m_count, m_count > 0);
      end
      next_cycle();
    end
    reset = 1'b1;
    idle_cycles(12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult_busy();
    test_mflo_stall();
    test_divu_addu();
    test_back_to_back();
    test_reset_mid();
    test_ex_stall_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_issue_scheduler.md
Name: mdu_issue_scheduler

Overview:
- Sequences access to the shared multiply/divide unit (HI/LO) from the ID stage of the 5-stage pipeline.
- Takes decoded MDU intent from the control unit (mduStart, DMUOPCode, MDU-use flag).
- Issues one MDU op per cycle to EX and tracks the multi-cycle busy window of mult/div.
- Stalls ID while an MDU instruction would collide with an in-flight operation.

Parameters:
- MUL_LATENCY, 5: busy cycles after a MULT/MULTU issue.
- DIV_LATENCY, 10: busy cycles after a DIV/DIVU issue.
- CNT_W, 4: countdown width. Must hold max(MUL_LATENCY, DIV_LATENCY).

Ports:
- clock  in  1  — system clock, rising edge.
- reset  in  1  — synchronous, active-low reset.
- id_valid  in  1  — ID holds a real instruction (not a bubble).
- id_mdu_use  in  1  — instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- id_mdu_op  in  mdu_operation_t  — decoded MDU opcode.
- id_flush  in  1  — squash the ID instruction this cycle.
- ex_stall  in  1  — downstream freeze; EX cannot accept a new op.
- stall_id  out  1  — hold PC/IF/ID and inject a bubble into EX.
- mdu_issue  out  1  — one-cycle pulse: op accepted into EX.
- mdu_issue_op  out  mdu_operation_t  — opcode qualified by mdu_issue.
- mdu_busy  out  1  — mult/div in flight.
- busy_count  out  CNT_W  — remaining busy cycles.

Behaviour:
- States:
  - IDLE, BUSY_MUL, BUSY_DIV.
  - Registers: state and count.
  - Reset value of every output: stall_id=0, mdu_issue=0, mdu_issue_op=MDU_START_SIGNED_MUL, mdu_busy=0, busy_count=0.
- Combinational outputs:
  - mdu_busy = (count != 0).
  - busy_count = count.
  - stall_id = id_valid & id_mdu_use & mdu_busy & ~id_flush.
  - mdu_issue = id_valid & id_mdu_use & ~mdu_busy & ~ex_stall & ~id_flush.
  - mdu_issue_op = id_mdu_op when mdu_issue is high, else MDU_START_SIGNED_MUL.
- Start ops:
  - Issue of MULT/MULTU loads count=MUL_LATENCY and sets state BUSY_MUL.
  - Issue of DIV/DIVU loads count=DIV_LATENCY and sets state BUSY_DIV.
  - Issue at cycle T gives busy in cycles T+1..T+LAT. The next MDU op can issue at T+LAT+1 at the earliest.
- Non-start ops (MFHI/MFLO/MTHI/MTLO): issue with zero busy time, so back-to-back issue is allowed. Count and state are unchanged.
- Countdown:
  - count decrements every cycle while nonzero, regardless of ex_stall.
  - The 1→0 transition returns state to IDLE.
- Non-MDU instructions (id_mdu_use=0) never assert stall_id, even while busy.
- id_flush has priority:
  - no stall and no issue;
  - an in-flight countdown continues.
- ex_stall while not busy: no issue and stall_id=0. The pipeline freeze already holds ID.
- Simultaneous stall_id and ex_stall: stall_id is still asserted. The outer pipeline ORs the two.
- Reset (active-low) asserted mid-operation: state=IDLE and count=0 on the next edge. The in-flight op is abandoned.
- Illegal state encoding: recover to IDLE with count=0.

Optional Feature:
- Macro MDU_STALL_CNT_EN.
- When defined:
  - adds output stall_cycles (32 bits);
  - it increments every cycle stall_id=1 and saturates at 32'hFFFF_FFFF;
  - reset clears it to 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package (alongside Definitions.sv): mdu_operation_t (already shared with the MDU), a new mdu_sched_state_t enum {IDLE, BUSY_MUL, BUSY_DIV}, and the default latency constants.
- One natural sub-module, mdu_busy_counter:
  - loadable down-counter with load/value inputs;
  - outputs count and nonzero flag.
- The issue/stall logic stays in the top level.

Test Plan:
- Reset release, then MULT at T → mdu_issue=1 at T; mdu_busy=1 at T+1..T+5 with busy_count 5,4,3,2,1; 0 at T+6.
- MULT at T, MFLO held in ID from T+1 → stall_id=1 at T+1..T+5; MFLO issues at T+6 with mdu_issue_op=MDU_READ_LO.
- DIVU, then an ADDU in ID at T+1 → stall_id=0; busy_count=10 at T+1; a following MFHI stalls until T+11.
- MTHI then MTLO on consecutive cycles while idle → two mdu_issue pulses, no stall, busy_count stays 0.
- DIV issued, reset asserted at T+3 → at T+4 busy_count=0 and mdu_busy=0; MULT at T+4 issues immediately.
- MULT with ex_stall=1 for 2 cycles, then 0 → no issue while ex_stall is high; issue on release; id_flush on the same op gives no issue and no stall. With MDU_STALL_CNT_EN, the stall scenario above leaves stall_cycles=5.
